life_count_sequencer: RTL

- Computes the next Game of Life state for one cell.
- Time-multiplexes one 3-bit ripple adder (adder3) to count live neighbours serially, one bit per cycle, then applies the Conway rule.
- Sits between the board/cell-update logic and the shared adder datapath; uses a start/busy/done handshake.

---
 rtl/life_count_sequencer_pkg.sv | 20 ++
 rtl/life_count_sequencer_if.sv | 24 ++
 rtl/adder3.sv | 19 +
 rtl/life_count_sequencer.sv | 100 ++++++++++
 4 files changed

// File: rtl/life_count_sequencer_pkg.sv
// Shared types, constants and the Conway rule for the serial live-neighbour counter.
package life_count_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BIRTH_COUNT      = 3;
    localparam int SURVIVE_COUNT    = 2;
    localparam int EARLY_DEAD_COUNT = 4;
    localparam int COUNT_W          = 4;

    function automatic logic life_rule(input logic [COUNT_W-1:0] count, input logic alive);
        return (count == COUNT_W'(BIRTH_COUNT)) ||
               ((count == COUNT_W'(SURVIVE_COUNT)) && alive);
    endfunction

endpackage

// File: rtl/life_count_sequencer_if.sv
// Request/result bundle between the cell-update logic (master) and the sequencer (slave).
interface life_count_sequencer_if
    import life_count_sequencer_pkg::*;
#(
    parameter int N_NEIGHBORS = 8
);
    logic                   start;
    logic [N_NEIGHBORS-1:0] neighbors;
    logic                   cell_alive;
    logic                   busy;
    logic                   done;
    logic                   next_alive;
    logic [COUNT_W-1:0]     live_count;

    modport master (
        output start, neighbors, cell_alive,
        input  busy, done, next_alive, live_count
    );

    modport slave (
        input  start, neighbors, cell_alive,
        output busy, done, next_alive, live_count
    );
endinterface

// File: rtl/adder3.sv
// 3-bit ripple-carry adder; the shared datapath the sequencer time-multiplexes.
module adder3 (
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic       c_in,
    output logic [2:0] sum,
    output logic       c_out
);
    logic [3:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < 3; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c_out = carry[3];
endmodule

// File: rtl/life_count_sequencer.sv
// Counts live neighbours one bit per cycle through a shared adder3, then applies Conway's rule.
module life_count_sequencer
    import life_count_sequencer_pkg::*;
#(
    parameter int N_NEIGHBORS = 8,
    parameter int EARLY_EXIT  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    life_count_sequencer_if.slave         bus
);
    localparam int IDX_W = (N_NEIGHBORS > 1) ? $clog2(N_NEIGHBORS) : 1;

    state_t                 state, state_nxt;
    logic [N_NEIGHBORS-1:0] nb_reg;
    logic                   cell_reg;
    logic [2:0]             acc;
    logic                   carry_sticky;
    logic [IDX_W-1:0]       idx;
    logic [COUNT_W-1:0]     res_count;
    logic                   res_alive;

    logic [2:0]             sum;
    logic                   c_out;
    logic [COUNT_W-1:0]     cur_count, new_count;
    logic                   last_bit, early_hit;

    adder3 u_adder3 (
        .a     (acc),
        .b     (3'b000),
        .c_in  (nb_reg[idx]),
        .sum   (sum),
        .c_out (c_out)
    );

    assign cur_count = {carry_sticky, acc};
    assign new_count = {carry_sticky | c_out, sum};
    assign last_bit  = (idx == IDX_W'(N_NEIGHBORS - 1));
    // Once four neighbours are seen the cell is dead regardless of the rest.
    assign early_hit = (EARLY_EXIT != 0) && (new_count >= COUNT_W'(EARLY_DEAD_COUNT));

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = ACCUM;
            ACCUM:   if (last_bit || early_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (state != IDLE);
        bus.done       = (state == DONE);
        bus.live_count = res_count;
        bus.next_alive = res_alive;
        if (state == DONE) begin
            bus.live_count = cur_count;
            bus.next_alive = life_rule(cur_count, cell_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            nb_reg       <= '0;
            cell_reg     <= 1'b0;
            acc          <= '0;
            carry_sticky <= 1'b0;
            idx          <= '0;
            res_count    <= '0;
            res_alive    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    nb_reg       <= bus.neighbors;
                    cell_reg     <= bus.cell_alive;
                    acc          <= '0;
                    carry_sticky <= 1'b0;
                    idx          <= '0;
                end
                ACCUM: begin
                    acc          <= sum;
                    carry_sticky <= carry_sticky | c_out;
                    idx          <= idx + 1'b1;
                end
                // Results presented combinationally in DONE are kept for the IDLE that follows.
                DONE: begin
                    res_count <= cur_count;
                    res_alive <= life_rule(cur_count, cell_reg);
                end
                default: ;
            endcase
        end
    end
endmodule
